// File: rtl/sim_pkg.sv
// Shared types and constants for the multi-memory simulation top.
// Covers FSM states, load/store func3 codes, opcodes and the tohost/timeout encodings.
package sim_pkg;

  typedef enum logic [1:0] {
    PROGRAM = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2
  } sim_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h8000_0000;
  localparam logic [30:0] FAIL_TIMEOUT        = 31'h7FFF_FFFF;

  function automatic int max_size(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/core.sv
// Single-cycle RV32I integer core: combinational fetch and load, stores strobed on write_data.
// Registers and PC clear while rst is high, so the host can hold it idle outside RUN.
module core
  import sim_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  output logic [31:0] memory_address,
  output logic [31:0] store_value,
  output logic        write_data,
  output logic [2:0]  func3,
  input  logic [31:0] load_value
);

  logic [31:0] regs [32];
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_v, rs2_v;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] next_pc, rd_val;
  logic        rd_we;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign rs1_v  = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_v  = (rs2 == 5'd0) ? '0 : regs[rs2];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  alu = alt ? (a - b) : (a + b);
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'b0, $signed(a) < $signed(b)};
      3'b011:  alu = {31'b0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? ($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    case (f3)
      3'b000:  branch_taken = (a == b);
      3'b001:  branch_taken = (a != b);
      3'b100:  branch_taken = ($signed(a) < $signed(b));
      3'b101:  branch_taken = ($signed(a) >= $signed(b));
      3'b110:  branch_taken = (a < b);
      3'b111:  branch_taken = (a >= b);
      default: branch_taken = 1'b0;
    endcase
  endfunction

  always_comb begin
    next_pc        = pc + 32'd4;
    rd_we          = 1'b0;
    rd_val         = '0;
    write_data     = 1'b0;
    func3          = instruction[14:12];
    store_value    = rs2_v;
    memory_address = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);
    case (opcode)
      OP_LUI:   begin rd_we = 1'b1; rd_val = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; rd_val = pc + imm_u; end
      OP_JAL: begin
        rd_we   = 1'b1;
        rd_val  = pc + 32'd4;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        rd_we   = 1'b1;
        rd_val  = pc + 32'd4;
        next_pc = (rs1_v + imm_i) & ~32'd1;
      end
      OP_BRANCH: if (branch_taken(func3, rs1_v, rs2_v)) next_pc = pc + imm_b;
      OP_LOAD:   begin rd_we = 1'b1; rd_val = load_value; end
      OP_STORE:  write_data = 1'b1;
      OP_IMM: begin
        rd_we  = 1'b1;
        rd_val = alu(func3, (func3 == 3'b101) && instruction[30], rs1_v, imm_i);
      end
      OP_REG: begin
        rd_we  = 1'b1;
        rd_val = alu(func3, instruction[30], rs1_v, rs2_v);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= next_pc;
      if (rd_we && (rd != 5'd0)) regs[rd] <= rd_val;
    end
  end

endmodule

// File: rtl/sim_data_mem.sv
// Byte-lane data RAM: combinational sign/zero-extending loads, clocked byte-enable stores.
// The programming port has priority; the two write sources are never active together.
module sim_data_mem
  import sim_pkg::*;
#(
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [2:0]           func3,
  input  logic                 we,
  output logic [31:0]          rdata,
  input  logic                 prog_we,
  input  logic [ADDR_SIZE-1:0] prog_addr,
  input  logic [31:0]          prog_data
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [31:0]          mem [DEPTH];
  logic [ADDR_SIZE-1:0] word_idx;
  logic [31:0]          word;
  logic [1:0]           lane;
  logic [7:0]           byte_v;
  logic [15:0]          half_v;
  logic [3:0]           be;
  logic [31:0]          wlanes;
  logic                 unused_addr_bits;

  // Upper address bits fall away, so accesses wrap modulo the memory size.
  assign word_idx         = addr[ADDR_SIZE+1:2];
  assign lane             = addr[1:0];
  assign word             = mem[word_idx];
  assign unused_addr_bits = ^addr[31:ADDR_SIZE+2];

  always_comb begin
    case (lane)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = addr[1] ? word[31:16] : word[15:0];
    case (func3)
      F3_B:    rdata = {{24{byte_v[7]}}, byte_v};
      F3_BU:   rdata = {24'b0, byte_v};
      F3_H:    rdata = {{16{half_v[15]}}, half_v};
      F3_HU:   rdata = {16'b0, half_v};
      default: rdata = word;
    endcase
  end

  always_comb begin
    be     = 4'b0000;
    wlanes = wdata;
    case (func3)
      F3_B: begin
        be     = 4'b0001 << lane;
        wlanes = {4{wdata[7:0]}};
      end
      F3_H: begin
        be     = addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata[15:0]}};
      end
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end else if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/sim_top_multi_mem.sv
// Simulation top: loads instruction/data memories, runs the core, then latches the tohost
// verdict or a watchdog timeout. Handshake: a word moves on a posedge with prog_valid && prog_ready.
module sim_top_multi_mem
  import sim_pkg::*;
#(
  parameter int          INST_MEM_ADDR_SIZE = 10,
  parameter int          DATA_MEM_ADDR_SIZE = 10,
  parameter logic [31:0] TOHOST_ADDR        = DEFAULT_TOHOST_ADDR,
  parameter logic [31:0] TIMEOUT_CYCLES     = 32'd100_000,
  localparam int         PROG_ADDR_SIZE     = max_size(INST_MEM_ADDR_SIZE, DATA_MEM_ADDR_SIZE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      prog_valid,
  output logic                      prog_ready,
  input  logic                      prog_target,
  input  logic [PROG_ADDR_SIZE-1:0] prog_addr,
  input  logic [31:0]               prog_data,
  input  logic                      prog_done,
  output logic                      result_valid,
  output logic                      result_passed,
  output logic [30:0]               fail_code,
  output logic [31:0]               cycle_count,
  output sim_state_e                dbg_state,
  output logic [31:0]               dbg_pc
);

  localparam int IMEM_DEPTH = 1 << INST_MEM_ADDR_SIZE;

  sim_state_e  state;
  logic [31:0] imem [IMEM_DEPTH];
  logic        core_rst;
  logic [31:0] pc, instruction, memory_address, store_value, load_value;
  logic        write_data;
  logic [2:0]  func3;
  logic        prog_accept, store_in_run, tohost_hit, dmem_we, timeout_hit;
  logic [31:0] count_next;
  logic        unused_pc_bits;

  assign prog_ready     = (state == PROGRAM);
  assign prog_accept    = prog_valid && prog_ready;
  assign core_rst       = reset || (state != RUN);
  assign instruction    = imem[pc[INST_MEM_ADDR_SIZE+1:2]];
  assign unused_pc_bits = ^{pc[31:INST_MEM_ADDR_SIZE+2], pc[1:0]};

  // Stores only take effect in RUN; the mailbox address never reaches the RAM.
  assign store_in_run = write_data && (state == RUN);
  assign tohost_hit   = store_in_run && (memory_address == TOHOST_ADDR);
  assign dmem_we      = store_in_run && (memory_address != TOHOST_ADDR);

  assign count_next  = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (count_next == TIMEOUT_CYCLES);

  assign dbg_state = state;
  assign dbg_pc    = pc;

  core u_core (
    .clk            (clk),
    .rst            (core_rst),
    .pc             (pc),
    .instruction    (instruction),
    .memory_address (memory_address),
    .store_value    (store_value),
    .write_data     (write_data),
    .func3          (func3),
    .load_value     (load_value)
  );

  sim_data_mem #(
    .ADDR_SIZE (DATA_MEM_ADDR_SIZE)
  ) u_dmem (
    .clk       (clk),
    .reset     (reset),
    .addr      (memory_address),
    .wdata     (store_value),
    .func3     (func3),
    .we        (dmem_we),
    .rdata     (load_value),
    .prog_we   (prog_accept && prog_target),
    .prog_addr (prog_addr[DATA_MEM_ADDR_SIZE-1:0]),
    .prog_data (prog_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < IMEM_DEPTH; i++) imem[i] <= '0;
    end else if (prog_accept && !prog_target) begin
      imem[prog_addr[INST_MEM_ADDR_SIZE-1:0]] <= prog_data;
    end
  end

  // A tohost store outranks a timeout landing on the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= PROGRAM;
      result_valid  <= 1'b0;
      result_passed <= 1'b0;
      fail_code     <= '0;
      cycle_count   <= '0;
    end else begin
      case (state)
        PROGRAM: if (prog_done) state <= RUN;
        RUN: begin
          cycle_count <= count_next;
          if (tohost_hit) begin
            result_valid  <= 1'b1;
            result_passed <= (store_value == 32'd1);
            fail_code     <= (store_value == 32'd1) ? '0 : store_value[31:1];
            state         <= DONE;
          end else if (timeout_hit) begin
            result_valid  <= 1'b1;
            result_passed <= 1'b0;
            fail_code     <= FAIL_TIMEOUT;
            state         <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_top_multi_mem.sv
// Bench for sim_top_multi_mem: programs small RV32I tests, predicts the tohost verdict with a
// byte-array memory model and checks it from an independent result monitor.
module tb_sim_top_multi_mem;
  import sim_pkg::*;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] JAL_SELF = 32'h0000_006F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        prog_valid = 1'b0;
  logic        prog_ready;
  logic        prog_target = 1'b0;
  logic [9:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        prog_done = 1'b0;
  logic        result_valid, result_passed;
  logic [30:0] fail_code;
  logic [31:0] cycle_count;
  sim_state_e  dbg_state;
  logic [31:0] dbg_pc;

  // clock / reset
  always #5 clk = ~clk;

  sim_top_multi_mem #(
    .TIMEOUT_CYCLES (32'd50)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .prog_valid    (prog_valid),
    .prog_ready    (prog_ready),
    .prog_target   (prog_target),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .prog_done     (prog_done),
    .result_valid  (result_valid),
    .result_passed (result_passed),
    .fail_code     (fail_code),
    .cycle_count   (cycle_count),
    .dbg_state     (dbg_state),
    .dbg_pc        (dbg_pc)
  );

  int total = 0;
  int bad = 0;
  int results_seen = 0;
  logic [63:0] exp_q[$];
  logic [63:0] cur_exp;
  logic        have_exp = 1'b0;
  logic        seen = 1'b0;
  logic [31:0] model_mem [1024];
  logic [31:0] imem_q[$];
  int          pre_idx[$];
  logic [31:0] pre_dat[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // scoreboard monitor: {passed, fail_code, cycle_count}
  always @(negedge clk) begin
    if (!result_valid) begin
      seen = 1'b0;
      have_exp = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      results_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result actual passed=%0b fail_code=%h required=no result",
                 result_passed, fail_code);
      end else begin
        cur_exp = exp_q.pop_front();
        have_exp = 1'b1;
        chk("result_passed", 64'(result_passed), 64'(cur_exp[63]));
        chk("fail_code", 64'(fail_code), 64'(cur_exp[62:32]));
        chk("cycle_count", 64'(cycle_count), 64'(cur_exp[31:0]));
      end
    end else if (have_exp) begin
      chk("result_hold", {result_passed, fail_code, cycle_count}, cur_exp);
    end
  end

  // instruction encoders
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  task automatic push_li(input logic [4:0] rd, input logic [31:0] v);
    logic [31:0] hi;
    hi = v + 32'h800;
    imem_q.push_back(enc_lui(rd, hi[31:12]));
    imem_q.push_back(enc_i(v[11:0], rd, 3'b000, rd, 7'b0010011));
  endtask

  // reference memory model, byte addressed, wrapping at 4 KiB
  function automatic void model_store(input logic [31:0] a, input logic [31:0] d,
                                      input logic [2:0] f3);
    int w, lane, half;
    w = int'((a / 32'd4) % 32'd1024);
    lane = int'(a % 32'd4);
    half = int'((a / 32'd2) % 32'd2);
    case (f3)
      3'd0: model_mem[w][8*lane +: 8] = d[7:0];
      3'd1: model_mem[w][16*half +: 16] = d[15:0];
      3'd2: model_mem[w] = d;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] word;
    logic [7:0]  b;
    logic [15:0] h;
    int lane, half;
    word = model_mem[int'((a / 32'd4) % 32'd1024)];
    lane = int'(a % 32'd4);
    half = int'((a / 32'd2) % 32'd2);
    b = word[8*lane +: 8];
    h = word[16*half +: 16];
    case (f3)
      3'd0:    return 32'($signed(b));
      3'd4:    return {24'b0, b};
      3'd1:    return 32'($signed(h));
      3'd5:    return {16'b0, h};
      default: return word;
    endcase
  endfunction

  // drivers
  task automatic do_reset();
    reset = 1'b1;
    prog_valid = 1'b0;
    prog_done = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    foreach (model_mem[i]) model_mem[i] = '0;
    chk("reset_prog_ready", 64'(prog_ready), 64'd1);
    chk("reset_result_valid", 64'(result_valid), 64'd0);
    chk("reset_result_passed", 64'(result_passed), 64'd0);
    chk("reset_fail_code", 64'(fail_code), 64'd0);
    chk("reset_cycle_count", 64'(cycle_count), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'(PROGRAM));
  endtask

  task automatic prog_word(input logic tgt, input int a, input logic [31:0] d, input logic done);
    if ($urandom_range(0, 2) == 0) begin
      @(posedge clk); #1;
    end
    prog_valid = 1'b1;
    prog_target = tgt;
    prog_addr = 10'(a);
    prog_data = d;
    prog_done = done;
    @(posedge clk); #1;
    prog_valid = 1'b0;
    prog_done = 1'b0;
  endtask

  task automatic load_and_start();
    logic combine;
    combine = 1'($urandom_range(0, 1));
    foreach (pre_idx[i]) prog_word(1'b1, pre_idx[i], pre_dat[i], 1'b0);
    foreach (imem_q[i]) prog_word(1'b0, i, imem_q[i], combine && (i == imem_q.size() - 1));
    if (!combine) begin
      prog_done = 1'b1;
      @(posedge clk); #1;
      prog_done = 1'b0;
    end
    chk("start_prog_ready", 64'(prog_ready), 64'd0);
    chk("start_state", 64'(dbg_state), 64'(RUN));
    chk("pc_step0", 64'(dbg_pc), 64'd0);
    @(posedge clk); #1;
    chk("pc_step1", 64'(dbg_pc), 64'd4);
    @(posedge clk); #1;
    chk("pc_step2", 64'(dbg_pc), 64'd8);
  endtask

  // prog_* must be ignored outside PROGRAM, so keep it busy with junk
  task automatic junk_cycle();
    prog_valid = 1'($urandom_range(0, 1));
    prog_target = 1'($urandom_range(0, 1));
    prog_addr = 10'($urandom_range(0, 15));
    prog_data = $urandom;
    prog_done = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
  endtask

  task automatic run_expect(input logic [63:0] exp);
    int start, n;
    exp_q.push_back(exp);
    start = results_seen;
    load_and_start();
    n = 0;
    while (results_seen == start && n < 200) begin
      junk_cycle();
      n++;
    end
    repeat (3) junk_cycle();
    prog_valid = 1'b0;
    prog_done = 1'b0;
    if (results_seen == start) begin
      total++;
      bad++;
      $display("FAIL result_wait actual=no result after %0d cycles required=result_valid", n);
      exp_q.delete();
    end
  endtask

  // store sdata at saddr, load laddr, shift, send to tohost, then a second ignored store
  task automatic ls_run(input logic [31:0] sdata, input logic [31:0] saddr, input logic [2:0] sf3,
                        input logic [31:0] laddr, input logic [2:0] lf3, input int shift);
    logic [31:0] v;
    do_reset();
    foreach (pre_idx[i]) model_mem[pre_idx[i]] = pre_dat[i];
    model_store(saddr, sdata, sf3);
    v = model_load(laddr, lf3) << shift;
    imem_q.delete();
    push_li(5'd1, sdata);
    push_li(5'd2, saddr);
    push_li(5'd6, laddr);
    imem_q.push_back(enc_s(12'd0, 5'd1, 5'd2, sf3));
    imem_q.push_back(enc_i(12'd0, 5'd6, lf3, 5'd3, 7'b0000011));
    imem_q.push_back(enc_i({7'b0, 5'(shift)}, 5'd3, 3'b001, 5'd3, 7'b0010011));
    imem_q.push_back(enc_lui(5'd4, 20'h80000));
    imem_q.push_back(enc_s(12'd0, 5'd3, 5'd4, 3'b010));
    imem_q.push_back(enc_i(12'd1, 5'd0, 3'b000, 5'd5, 7'b0010011));
    imem_q.push_back(enc_s(12'd0, 5'd5, 5'd4, 3'b010));
    imem_q.push_back(JAL_SELF);
    run_expect({v == 32'd1, (v == 32'd1) ? 31'd0 : v[31:1], 32'd11});
  endtask

  function automatic logic [31:0] rand_upper();
    case ($urandom_range(0, 2))
      0:       return 32'h0;
      1:       return 32'h1000;
      default: return 32'h0040_0000;
    endcase
  endfunction

  initial begin
    int sw, lw, wait_n;
    logic [31:0] saddr, laddr;

    do_reset();

    // timeout on an endless loop
    pre_idx.delete(); pre_dat.delete(); imem_q.delete();
    imem_q = '{NOP, NOP, NOP, JAL_SELF};
    run_expect({1'b0, FAIL_TIMEOUT, 32'd50});

    // tohost pass, later store of 7 ignored
    do_reset();
    imem_q.delete();
    imem_q.push_back(NOP);
    imem_q.push_back(NOP);
    imem_q.push_back(enc_i(12'd1, 5'd0, 3'b000, 5'd5, 7'b0010011));
    imem_q.push_back(enc_lui(5'd4, 20'h80000));
    imem_q.push_back(enc_s(12'd0, 5'd5, 5'd4, 3'b010));
    imem_q.push_back(enc_i(12'd7, 5'd0, 3'b000, 5'd5, 7'b0010011));
    imem_q.push_back(enc_s(12'd0, 5'd5, 5'd4, 3'b010));
    imem_q.push_back(JAL_SELF);
    run_expect({1'b1, 31'd0, 32'd5});

    // tohost fail with 7, later store of 1 ignored
    do_reset();
    imem_q.delete();
    imem_q.push_back(enc_i(12'd7, 5'd0, 3'b000, 5'd5, 7'b0010011));
    imem_q.push_back(enc_lui(5'd4, 20'h80000));
    imem_q.push_back(enc_s(12'd0, 5'd5, 5'd4, 3'b010));
    imem_q.push_back(enc_i(12'd1, 5'd0, 3'b000, 5'd5, 7'b0010011));
    imem_q.push_back(enc_s(12'd0, 5'd5, 5'd4, 3'b010));
    imem_q.push_back(JAL_SELF);
    run_expect({1'b0, 31'd3, 32'd3});

    // sub-word loads of 0xDEADBEEF and a byte store into 0x11223344
    ls_run(32'hDEAD_BEEF, 32'h10, F3_W, 32'h13, F3_B, 0);
    ls_run(32'hDEAD_BEEF, 32'h10, F3_W, 32'h13, F3_BU, 1);
    ls_run(32'hDEAD_BEEF, 32'h10, F3_W, 32'h12, F3_H, 0);
    ls_run(32'hDEAD_BEEF, 32'h10, F3_W, 32'h12, F3_HU, 1);
    pre_idx.push_back(4); pre_dat.push_back(32'h1122_3344);
    ls_run(32'h0000_005A, 32'h11, F3_B, 32'h10, F3_W, 1);
    pre_idx.delete(); pre_dat.delete();

    // reset mid-RUN after a store, then read the location back
    do_reset();
    imem_q.delete();
    push_li(5'd1, 32'hDEAD_BEEF);
    push_li(5'd2, 32'h10);
    imem_q.push_back(enc_s(12'd0, 5'd1, 5'd2, 3'b010));
    imem_q.push_back(JAL_SELF);
    load_and_start();
    wait_n = $urandom_range(5, 20);
    repeat (wait_n) junk_cycle();
    do_reset();
    ls_run(32'h0, 32'h10, 3'b011, 32'h10, F3_W, 0);

    // randomized load/store traffic
    for (int r = 0; r < 24; r++) begin
      pre_idx.delete(); pre_dat.delete();
      if ($urandom_range(0, 3) != 0) begin
        repeat ($urandom_range(1, 6)) begin
          pre_idx.push_back($urandom_range(0, 15));
          pre_dat.push_back($urandom);
        end
      end
      sw = $urandom_range(0, 15);
      lw = ($urandom_range(0, 1) == 1) ? sw : $urandom_range(0, 15);
      saddr = rand_upper() + 32'(sw * 4) + 32'($urandom_range(0, 3));
      laddr = rand_upper() + 32'(lw * 4) + 32'($urandom_range(0, 3));
      ls_run($urandom, saddr, 3'($urandom_range(0, 3)), laddr, 3'($urandom_range(0, 7)),
             $urandom_range(0, 1));
    end

    do_reset();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
